// File: rtl/axil2iob.sv
// axil2iob: AXI4-Lite slave to native valid/ready master bridge; define AXIL2IOB_RR_ARB_EN for round-robin read/write arbitration (default: fixed write priority)
module axil2iob #(
  parameter int AXIL_ADDR_W = 32,
  parameter int AXIL_DATA_W = 32,
  parameter int AXI_ID_W = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [AXI_ID_W-1:0]      axil_awid,
  input  logic [AXIL_ADDR_W-1:0]   axil_awaddr,
  input  logic [2:0]               axil_awprot,
  input  logic [3:0]               axil_awqos,
  input  logic                     axil_awvalid,
  output logic                     axil_awready,
  input  logic [AXIL_DATA_W-1:0]   axil_wdata,
  input  logic [AXIL_DATA_W/8-1:0] axil_wstrb,
  input  logic                     axil_wvalid,
  output logic                     axil_wready,
  output logic [AXI_ID_W-1:0]      axil_bid,
  output logic [1:0]               axil_bresp,
  output logic                     axil_bvalid,
  input  logic                     axil_bready,
  input  logic [AXI_ID_W-1:0]      axil_arid,
  input  logic [AXIL_ADDR_W-1:0]   axil_araddr,
  input  logic [2:0]               axil_arprot,
  input  logic [3:0]               axil_arqos,
  input  logic                     axil_arvalid,
  output logic                     axil_arready,
  output logic [AXI_ID_W-1:0]      axil_rid,
  output logic [AXIL_DATA_W-1:0]   axil_rdata,
  output logic [1:0]               axil_rresp,
  output logic                     axil_rvalid,
  input  logic                     axil_rready,
  output logic                     valid,
  output logic [AXIL_ADDR_W-1:0]   addr,
  output logic [AXIL_DATA_W-1:0]   wdata,
  output logic [AXIL_DATA_W/8-1:0] wstrb,
  input  logic [AXIL_DATA_W-1:0]   rdata,
  input  logic                     ready
);
  typedef enum logic [2:0] {IDLE, WRITE, READ, BRESP, RRESP} state_t;
  state_t state;
  logic aw_full, w_full, ar_full;
  logic [AXI_ID_W-1:0] aw_id, ar_id;
  logic [AXIL_ADDR_W-1:0] aw_addr, ar_addr;
  logic [AXIL_DATA_W-1:0] w_data;
  logic [AXIL_DATA_W/8-1:0] w_strb;
  logic aw_hs, w_hs, ar_hs;
  logic [AXI_ID_W-1:0] aw_id_n;
  logic [AXIL_ADDR_W-1:0] aw_addr_n, ar_addr_n;
  logic [AXIL_DATA_W-1:0] w_data_n;
  logic [AXIL_DATA_W/8-1:0] w_strb_n;
  logic wr_pend, rd_pend, pick_wr, pick_rd, wr_done, rd_done;
  logic unused_sideband;
  assign unused_sideband = ^{axil_awprot, axil_arprot, axil_awqos, axil_arqos};
  assign axil_bresp = 2'b00;
  assign axil_rresp = 2'b00;
  assign aw_hs = axil_awvalid & axil_awready;
  assign w_hs = axil_wvalid & axil_wready;
  assign ar_hs = axil_arvalid & axil_arready;
  // holding-register contents including a handshake landing this cycle, so IDLE can launch on the capturing edge
  always_comb begin
    aw_id_n = aw_hs ? axil_awid : aw_id;
    aw_addr_n = aw_hs ? axil_awaddr : aw_addr;
    ar_addr_n = ar_hs ? axil_araddr : ar_addr;
    w_data_n = w_hs ? axil_wdata : w_data;
    w_strb_n = w_hs ? axil_wstrb : w_strb;
    wr_pend = (aw_full | aw_hs) & (w_full | w_hs);
    rd_pend = ar_full | ar_hs;
  end
`ifdef AXIL2IOB_RR_ARB_EN
  logic last_read;
  // remember which kind of native access completed last so the other kind wins the next tie
  always_ff @(posedge clk or posedge rst)
    if (rst) last_read <= 1'b1;
    else if (ready && state == WRITE) last_read <= 1'b0;
    else if (ready && state == READ) last_read <= 1'b1;
  assign pick_wr = (state == IDLE) & wr_pend & (~rd_pend | last_read);
`else
  assign pick_wr = (state == IDLE) & wr_pend;
`endif
  assign pick_rd = (state == IDLE) & rd_pend & ~pick_wr;
  assign wr_done = (state == WRITE & ready) | (pick_wr & w_strb_n == '0);
  assign rd_done = state == READ & ready;
  // capture AW, W and AR independently; each register frees itself when its transaction completes
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      aw_full <= 1'b0;
      w_full <= 1'b0;
      ar_full <= 1'b0;
      axil_awready <= 1'b0;
      axil_wready <= 1'b0;
      axil_arready <= 1'b0;
      aw_id <= '0;
      aw_addr <= '0;
      w_data <= '0;
      w_strb <= '0;
      ar_id <= '0;
      ar_addr <= '0;
    end else begin
      aw_full <= (aw_full | aw_hs) & ~wr_done;
      w_full <= (w_full | w_hs) & ~wr_done;
      ar_full <= (ar_full | ar_hs) & ~rd_done;
      axil_awready <= ~((aw_full | aw_hs) & ~wr_done);
      axil_wready <= ~((w_full | w_hs) & ~wr_done);
      axil_arready <= ~((ar_full | ar_hs) & ~rd_done);
      if (aw_hs) begin
        aw_id <= axil_awid;
        aw_addr <= axil_awaddr;
      end
      if (w_hs) begin
        w_data <= axil_wdata;
        w_strb <= axil_wstrb;
      end
      if (ar_hs) begin
        ar_id <= axil_arid;
        ar_addr <= axil_araddr;
      end
    end
  // one native transaction at a time, then hold its AXI response until accepted
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      valid <= 1'b0;
      addr <= '0;
      wdata <= '0;
      wstrb <= '0;
      axil_bvalid <= 1'b0;
      axil_bid <= '0;
      axil_rvalid <= 1'b0;
      axil_rid <= '0;
      axil_rdata <= '0;
    end else
      case (state)
        IDLE:
          if (pick_wr && w_strb_n != '0) begin
            state <= WRITE;
            valid <= 1'b1;
            addr <= aw_addr_n;
            wdata <= w_data_n;
            wstrb <= w_strb_n;
          end else if (pick_wr) begin
            state <= BRESP;
            axil_bid <= aw_id_n;
          end else if (pick_rd) begin
            state <= READ;
            valid <= 1'b1;
            addr <= ar_addr_n;
            wstrb <= '0;
          end
        WRITE:
          if (ready) begin
            state <= BRESP;
            valid <= 1'b0;
            axil_bvalid <= 1'b1;
            axil_bid <= aw_id;
          end
        READ:
          if (ready) begin
            state <= RRESP;
            valid <= 1'b0;
            axil_rvalid <= 1'b1;
            axil_rid <= ar_id;
            axil_rdata <= rdata;
          end
        BRESP:
          if (!axil_bvalid) axil_bvalid <= 1'b1;
          else if (axil_bready) begin
            axil_bvalid <= 1'b0;
            state <= IDLE;
          end
        RRESP:
          if (axil_rready) begin
            axil_rvalid <= 1'b0;
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_axil2iob.sv
// tb_axil2iob: directed self-checking bench for the axil2iob bridge
module tb_axil2iob;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [0:0] axil_awid, axil_bid, axil_arid, axil_rid;
  logic [31:0] axil_awaddr, axil_araddr, axil_wdata, axil_rdata, addr, wdata, rdata;
  logic [3:0] axil_wstrb, wstrb, axil_awqos, axil_arqos;
  logic [2:0] axil_awprot, axil_arprot;
  logic [1:0] axil_bresp, axil_rresp;
  logic axil_awvalid, axil_awready, axil_wvalid, axil_wready, axil_bvalid, axil_bready;
  logic axil_arvalid, axil_arready, axil_rvalid, axil_rready, valid, ready;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  axil2iob dut (
    .clk(clk), .rst(rst),
    .axil_awid(axil_awid), .axil_awaddr(axil_awaddr), .axil_awprot(axil_awprot), .axil_awqos(axil_awqos),
    .axil_awvalid(axil_awvalid), .axil_awready(axil_awready),
    .axil_wdata(axil_wdata), .axil_wstrb(axil_wstrb), .axil_wvalid(axil_wvalid), .axil_wready(axil_wready),
    .axil_bid(axil_bid), .axil_bresp(axil_bresp), .axil_bvalid(axil_bvalid), .axil_bready(axil_bready),
    .axil_arid(axil_arid), .axil_araddr(axil_araddr), .axil_arprot(axil_arprot), .axil_arqos(axil_arqos),
    .axil_arvalid(axil_arvalid), .axil_arready(axil_arready),
    .axil_rid(axil_rid), .axil_rdata(axil_rdata), .axil_rresp(axil_rresp), .axil_rvalid(axil_rvalid),
    .axil_rready(axil_rready),
    .valid(valid), .addr(addr), .wdata(wdata), .wstrb(wstrb), .rdata(rdata), .ready(ready)
  );
  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({axil_awready, axil_wready, axil_arready, valid, axil_bvalid, axil_rvalid} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 000000", {axil_awready, axil_wready, axil_arready, valid, axil_bvalid, axil_rvalid});
    end
    checks++;
    if ({addr, wdata, wstrb, axil_bid, axil_rid, axil_bresp, axil_rresp, axil_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_data: addr %h wdata %h wstrb %h rdata %h, all expected 0", addr, wdata, wstrb, axil_rdata);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({axil_awready, axil_wready, axil_arready} !== 3'b111) begin
      errors++;
      $display("FAIL reset_release_ready: got %b expected 111", {axil_awready, axil_wready, axil_arready});
    end
  endtask
  task automatic test_single_write();
    axil_awid = 1'b1; axil_awaddr = 32'h10; axil_awvalid = 1'b1;
    axil_wdata = 32'hDEADBEEF; axil_wstrb = 4'hF; axil_wvalid = 1'b1;
    @(negedge clk);
    axil_awvalid = 1'b0; axil_wvalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if ({valid, addr, wdata, wstrb} !== {1'b1, 32'h10, 32'hDEADBEEF, 4'hF}) begin
        errors++;
        $display("FAIL write_native[%0d]: got valid %b addr %h wdata %h wstrb %h expected 1 10 deadbeef f", c, valid, addr, wdata, wstrb);
      end
      if (c < 2) @(negedge clk);
    end
    checks++;
    if ({axil_awready, axil_wready, axil_bvalid} !== 3'b000) begin
      errors++;
      $display("FAIL write_busy: got awready,wready,bvalid %b expected 000", {axil_awready, axil_wready, axil_bvalid});
    end
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    checks++;
    if ({valid, axil_bvalid, axil_bid, axil_bresp} !== 5'b01100) begin
      errors++;
      $display("FAIL write_resp: got valid,bvalid,bid,bresp %b expected 01100", {valid, axil_bvalid, axil_bid, axil_bresp});
    end
    checks++;
    if ({axil_awready, axil_wready} !== 2'b11) begin
      errors++;
      $display("FAIL write_freed: got %b expected 11", {axil_awready, axil_wready});
    end
    @(negedge clk);
    checks++;
    if (axil_bvalid !== 1'b1) begin
      errors++;
      $display("FAIL write_bhold: got bvalid %b expected 1", axil_bvalid);
    end
    axil_bready = 1'b1;
    @(negedge clk);
    axil_bready = 1'b0;
    checks++;
    if (axil_bvalid !== 1'b0) begin
      errors++;
      $display("FAIL write_bdone: got bvalid %b expected 0", axil_bvalid);
    end
  endtask
  task automatic test_single_read();
    axil_arid = 1'b1; axil_araddr = 32'h20; axil_arvalid = 1'b1;
    @(negedge clk);
    axil_arvalid = 1'b0;
    checks++;
    if ({valid, addr, wstrb, axil_arready} !== {1'b1, 32'h20, 4'h0, 1'b0}) begin
      errors++;
      $display("FAIL read_native: got valid %b addr %h wstrb %h arready %b expected 1 20 0 0", valid, addr, wstrb, axil_arready);
    end
    ready = 1'b1; rdata = 32'h12345678;
    @(negedge clk);
    ready = 1'b0; rdata = 32'hFFFFFFFF;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if ({valid, axil_rvalid, axil_rid, axil_rresp, axil_rdata} !== {1'b0, 1'b1, 1'b1, 2'b00, 32'h12345678}) begin
        errors++;
        $display("FAIL read_resp[%0d]: got valid %b rvalid %b rid %b rresp %b rdata %h expected 0 1 1 00 12345678", c, valid, axil_rvalid, axil_rid, axil_rresp, axil_rdata);
      end
      if (c < 3) @(negedge clk);
    end
    axil_rready = 1'b1;
    @(negedge clk);
    axil_rready = 1'b0;
    checks++;
    if ({axil_rvalid, axil_arready} !== 2'b01) begin
      errors++;
      $display("FAIL read_done: got rvalid,arready %b expected 01", {axil_rvalid, axil_arready});
    end
  endtask
  task automatic test_split_order();
    for (int k = 0; k < 2; k++) begin
      axil_awid = 1'b0; axil_awaddr = 32'h30 + 32'(k * 4);
      axil_wdata = 32'h11110000 + 32'(k); axil_wstrb = 4'h3;
      if (k == 0) axil_wvalid = 1'b1;
      else axil_awvalid = 1'b1;
      @(negedge clk);
      axil_wvalid = 1'b0; axil_awvalid = 1'b0;
      for (int c = 0; c < 2; c++) begin
        checks++;
        if (valid !== 1'b0) begin
          errors++;
          $display("FAIL split_early[%0d/%0d]: got valid %b expected 0", k, c, valid);
        end
        if (c == 0) @(negedge clk);
      end
      if (k == 0) axil_awvalid = 1'b1;
      else axil_wvalid = 1'b1;
      @(negedge clk);
      axil_wvalid = 1'b0; axil_awvalid = 1'b0;
      checks++;
      if ({valid, addr, wdata, wstrb} !== {1'b1, 32'h30 + 32'(k * 4), 32'h11110000 + 32'(k), 4'h3}) begin
        errors++;
        $display("FAIL split_native[%0d]: got valid %b addr %h wdata %h wstrb %h", k, valid, addr, wdata, wstrb);
      end
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
      axil_bready = 1'b1;
      checks++;
      if ({valid, axil_bvalid} !== 2'b01) begin
        errors++;
        $display("FAIL split_resp[%0d]: got valid,bvalid %b expected 01", k, {valid, axil_bvalid});
      end
      @(negedge clk);
      axil_bready = 1'b0;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        checks++;
        if ({valid, axil_bvalid} !== 2'b00) begin
          errors++;
          $display("FAIL split_single[%0d/%0d]: got valid,bvalid %b expected 00", k, c, {valid, axil_bvalid});
        end
      end
    end
  endtask
  task automatic test_zero_strobe();
    axil_awid = 1'b0; axil_awaddr = 32'h40; axil_awvalid = 1'b1;
    axil_wdata = 32'hCAFE; axil_wstrb = 4'h0; axil_wvalid = 1'b1;
    @(negedge clk);
    axil_awvalid = 1'b0; axil_wvalid = 1'b0;
    checks++;
    if ({valid, axil_bvalid} !== 2'b00) begin
      errors++;
      $display("FAIL zero_n1: got valid,bvalid %b expected 00", {valid, axil_bvalid});
    end
    @(negedge clk);
    checks++;
    if ({valid, axil_bvalid, axil_bid, axil_bresp} !== 5'b01000) begin
      errors++;
      $display("FAIL zero_n2: got valid,bvalid,bid,bresp %b expected 01000", {valid, axil_bvalid, axil_bid, axil_bresp});
    end
    axil_bready = 1'b1;
    @(negedge clk);
    axil_bready = 1'b0;
    checks++;
    if ({valid, axil_bvalid} !== 2'b00) begin
      errors++;
      $display("FAIL zero_done: got valid,bvalid %b expected 00", {valid, axil_bvalid});
    end
  endtask
  task automatic test_arbitration();
    logic [31:0] seen[$];
    logic [31:0] exp_order[8];
    int nb = 0;
    int nr = 0;
`ifdef AXIL2IOB_RR_ARB_EN
    exp_order = '{32'h100, 32'h200, 32'h104, 32'h204, 32'h108, 32'h208, 32'h10C, 32'h20C};
`else
    exp_order = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h200, 32'h204, 32'h208, 32'h20C};
`endif
    axil_bready = 1'b1; axil_rready = 1'b1;
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          axil_awid = 1'(i); axil_awaddr = 32'h100 + 32'(i * 4); axil_awvalid = 1'b1;
          axil_wdata = 32'(i); axil_wstrb = 4'hF; axil_wvalid = 1'b1;
          for (int t = 0; t < 60 && !(axil_awready && axil_wready); t++) @(negedge clk);
          @(negedge clk);
        end
        axil_awvalid = 1'b0; axil_wvalid = 1'b0;
      end
      begin
        for (int i = 0; i < 4; i++) begin
          axil_arid = 1'(i); axil_araddr = 32'h200 + 32'(i * 4); axil_arvalid = 1'b1;
          for (int t = 0; t < 60 && !axil_arready; t++) @(negedge clk);
          @(negedge clk);
        end
        axil_arvalid = 1'b0;
      end
      begin
        for (int t = 0; t < 80; t++) begin
          @(negedge clk);
          nb += int'(axil_bvalid);
          nr += int'(axil_rvalid);
          if (valid && !ready) begin
            seen.push_back(addr);
            ready = 1'b1;
            rdata = addr;
          end else ready = 1'b0;
        end
        ready = 1'b0;
      end
    join
    axil_bready = 1'b0; axil_rready = 1'b0;
    checks++;
    if (seen.size() != 8) begin
      errors++;
      $display("FAIL arb_count: got %0d native accesses expected 8", seen.size());
    end
    for (int i = 0; i < seen.size() && i < 8; i++) begin
      checks++;
      if (seen[i] !== exp_order[i]) begin
        errors++;
        $display("FAIL arb_order[%0d]: got addr %h expected %h", i, seen[i], exp_order[i]);
      end
    end
    checks++;
    if (nb != 4 || nr != 4) begin
      errors++;
      $display("FAIL arb_responses: got %0d b and %0d r expected 4 and 4", nb, nr);
    end
  endtask
  task automatic test_rst_mid();
    axil_arid = 1'b0; axil_araddr = 32'h50; axil_arvalid = 1'b1;
    @(negedge clk);
    axil_arvalid = 1'b0;
    checks++;
    if ({valid, addr} !== {1'b1, 32'h50}) begin
      errors++;
      $display("FAIL rst_pre: got valid %b addr %h expected 1 50", valid, addr);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({valid, axil_rvalid, axil_arready, axil_awready, addr} !== '0) begin
      errors++;
      $display("FAIL rst_async: got valid %b rvalid %b arready %b awready %b addr %h all expected 0", valid, axil_rvalid, axil_arready, axil_awready, addr);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({axil_awready, axil_wready, axil_arready} !== 3'b111) begin
      errors++;
      $display("FAIL rst_ready: got %b expected 111", {axil_awready, axil_wready, axil_arready});
    end
    axil_rready = 1'b1; axil_bready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if ({valid, axil_rvalid, axil_bvalid} !== 3'b000) begin
        errors++;
        $display("FAIL rst_stale[%0d]: got valid,rvalid,bvalid %b expected 000", c, {valid, axil_rvalid, axil_bvalid});
      end
    end
    axil_rready = 1'b0; axil_bready = 1'b0;
  endtask
  initial begin
    axil_awid = '0; axil_awaddr = '0; axil_awprot = '0; axil_awqos = '0; axil_awvalid = 1'b0;
    axil_wdata = '0; axil_wstrb = '0; axil_wvalid = 1'b0; axil_bready = 1'b0;
    axil_arid = '0; axil_araddr = '0; axil_arprot = '0; axil_arqos = '0; axil_arvalid = 1'b0;
    axil_rready = 1'b0; rdata = '0; ready = 1'b0;
    test_reset();
    test_single_write();
    test_single_read();
    test_split_order();
    test_zero_strobe();
    test_arbitration();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/axil2iob.md
# axil2iob

AXI4-Lite slave to native (IOb) master bridge. Accepts single-beat AXI4-Lite read and write transactions from an interconnect or CPU bus and replays them one at a time on the native valid/ready port. It sits downstream of an AXI4-Lite master, such as the native-to-AXI-Lite bridge, so native peripherals can be attached behind an AXI4-Lite fabric.

## Interface
- AXIL_ADDR_W, 32, address width of both AXI4-Lite and native ports
- AXIL_DATA_W, 32, data width; strobe width AXIL_DATA_W/8
- AXI_ID_W, 1, width of AXI ID fields (awid/arid echoed on bid/rid)

Ports (reset rst, asynchronous, active-high; clock clk):
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- axil_awid/awaddr/awvalid  in  AXI_ID_W/AXIL_ADDR_W/1  write address channel
- axil_awready  out  1  write address ready
- axil_wdata/wstrb/wvalid  in  AXIL_DATA_W/AXIL_DATA_W/8/1  write data channel
- axil_wready  out  1  write data ready
- axil_bid/bresp/bvalid  out  AXI_ID_W/2/1  write response; axil_bready in 1
- axil_arid/araddr/arvalid  in  AXI_ID_W/AXIL_ADDR_W/1  read address channel
- axil_arready  out  1  read address ready
- axil_rid/rdata/rresp/rvalid  out  AXI_ID_W/AXIL_DATA_W/2/1  read data channel; axil_rready in 1
- awprot/arprot/awqos/arqos  in  3/3/4/4  accepted, ignored
- valid  out  1  native request
- addr  out  AXIL_ADDR_W  native address
- wdata  out  AXIL_DATA_W  native write data
- wstrb  out  AXIL_DATA_W/8  native strobes; 0 means read
- rdata  in  AXIL_DATA_W  native read data, valid in the cycle ready is high for a read
- ready  in  1  native completion, single-cycle pulse

## Operation
- Three holding registers: AW (id, addr), W (data, strb), AR (id, addr), each with a full flag.
- awready/wready/arready are registered and equal ~full. The full flag is set on handshake and cleared when the owning transaction completes on the native side. AW and W are captured independently, in either order.
- FSM states: IDLE, WRITE, READ, BRESP, RRESP.
- IDLE: write is pending when AW full and W full; read is pending when AR full. Both pending resolves by arbitration (see Configuration). Write selected: go to WRITE if wstrb≠0; if wstrb==0, clear AW and W and go directly to BRESP with no native access.
- WRITE: valid=1, addr=awaddr, wdata, wstrb from the holding registers. On ready: clear AW and W full flags, bvalid←1, bid←awid, bresp←2'b00, go to BRESP.
- READ: valid=1, addr=araddr, wstrb=0. On ready: rdata register←native rdata, rvalid←1, rid←arid, rresp←2'b00, clear AR full, go to RRESP.
- BRESP: hold bvalid, bid and bresp until bready, then bvalid←0 and go to IDLE. RRESP behaves the same with rvalid and rready.
- Native outputs stay stable while valid=1. valid drops in the cycle after ready.
- Responses are always OKAY. No error or timeout generation.

## Timing
- Reset values: all ready, valid and response outputs 0; bid, rid, bresp, rresp, rdata, addr, wdata and wstrb all 0. Ready outputs rise in the first clock after rst deasserts.
- Write: last of AW/W handshake at cycle N → valid at N+1. With ready at N+1, bvalid at N+2. Each native wait cycle adds one cycle.
- Read: AR handshake at N → valid at N+1. With ready at N+1, rvalid and rdata at N+2.
- Zero-strobe write: bvalid at N+2 with no valid pulse.
- A new AW/W/AR can be accepted while the previous transaction is in a response state, once its holding register has been freed. At most one outstanding native transaction.
- Response back-pressure: IDLE is not re-entered until the response handshake. A held bready=0 stalls further native traffic.
- rst mid-transaction: every register is cleared asynchronously, valid drops immediately, and the pending transaction is discarded with no response.

## Configuration
- AXIL2IOB_RR_ARB_EN defined: round-robin arbitration. A last-served flag is updated at each native completion. When both are pending, the type not served last wins. After reset the flag reads "read", so write goes first.
- Not defined: fixed write priority. When both are pending, write always wins, and a read waits until no complete write is pending.

## Test plan
- Single write: AW addr 0x10 and W data 0xDEADBEEF, wstrb 0xF, same cycle; ready after 2 wait cycles → one valid burst with addr 0x10/wdata 0xDEADBEEF/wstrb 0xF, then bvalid with bresp 0, bid=awid.
- Single read: AR addr 0x20, native returns 0x12345678 → wstrb 0 during valid; rvalid with rdata 0x12345678, rresp 0; rready held low 3 cycles keeps rvalid and rdata stable.
- W two cycles before AW, and separately AW before W → exactly one native write in each case, issued after the second handshake.
- AW+W and AR pending in the same cycle, repeated 4 times → write first in both builds. With AXIL2IOB_RR_ARB_EN, order alternates W,R,W,R. Without it, all writes complete before reads.
- Write with wstrb 0x0 → no valid pulse; bvalid 2 cycles after the handshake.
- rst asserted while valid=1 in READ → valid, rvalid and arready go to 0 immediately. After release, ready outputs return to 1 and no stale response is emitted.
